// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter in front of a single-port word-addressed data memory.
// Converts byte accesses to word accesses, merges sub-word stores and formats load data.
module dmem_arbiter #(
    parameter int DMEM_WORDS = 1024
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [1:0]  M_REQ,
    input  logic [1:0]  M_WE,
    input  logic [63:0] M_ADDR,
    input  logic [63:0] M_WDATA,
    input  logic [3:0]  M_SIZE,
    input  logic [1:0]  M_SIGNED,
    output logic [1:0]  M_GNT,
    output logic [1:0]  M_RVALID,
    output logic [31:0] M_RDATA,
    output logic        M_ERR,
    output logic        AWVALID,
    output logic [31:0] AWADDR,
    output logic [31:0] WDATA,
    output logic [31:0] ARADDR,
    input  logic [31:0] RDATA
);

    localparam logic [31:0] DEPTH = 32'(DMEM_WORDS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_RESP
    } state_t;

    state_t      state;
    state_t      state_next;
    logic        rr;
    logic        rr_next;
    logic        winner;
    logic        grant_any;

    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;
    logic [1:0]  sel_size;
    logic        sel_we;
    logic        sel_signed;
    logic        sel_err;

    logic        port_q;
    logic        we_q;
    logic        signed_q;
    logic        err_q;
    logic [1:0]  size_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] result_q;

    logic [31:0] shifted;
    logic [31:0] load_data;
    logic [31:0] store_data;
    logic [31:0] word_idx;

    // A lone requester wins outright; rr only breaks ties.
    always_comb begin
        grant_any = |M_REQ;
        case (M_REQ)
            2'b01:   winner = 1'b0;
            2'b10:   winner = 1'b1;
            2'b11:   winner = rr;
            default: winner = 1'b0;
        endcase
    end

    always_comb begin
        sel_addr   = winner ? M_ADDR[63:32]  : M_ADDR[31:0];
        sel_wdata  = winner ? M_WDATA[63:32] : M_WDATA[31:0];
        sel_size   = winner ? M_SIZE[3:2]    : M_SIZE[1:0];
        sel_we     = winner ? M_WE[1]        : M_WE[0];
        sel_signed = winner ? M_SIGNED[1]    : M_SIGNED[0];
        sel_err    = 1'b0;
        if (sel_size == 2'b11) begin
            sel_err = 1'b1;
        end
        if (sel_size == 2'b01 && sel_addr[0]) begin
            sel_err = 1'b1;
        end
        if (sel_size == 2'b10 && sel_addr[1:0] != 2'b00) begin
            sel_err = 1'b1;
        end
        if ({2'b00, sel_addr[31:2]} >= DEPTH) begin
            sel_err = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= S_IDLE;
            rr       <= 1'b0;
            port_q   <= 1'b0;
            we_q     <= 1'b0;
            signed_q <= 1'b0;
            err_q    <= 1'b0;
            size_q   <= 2'b00;
            addr_q   <= '0;
            wdata_q  <= '0;
            result_q <= '0;
        end else begin
            state <= state_next;
            rr    <= rr_next;
            if (state == S_IDLE && grant_any) begin
                port_q   <= winner;
                we_q     <= sel_we;
                signed_q <= sel_signed;
                err_q    <= sel_err;
                size_q   <= sel_size;
                addr_q   <= sel_addr;
                wdata_q  <= sel_wdata;
            end
            if (state == S_ACCESS) begin
                result_q <= (we_q || err_q) ? 32'd0 : load_data;
            end
        end
    end

    always_comb begin
        state_next = state;
        rr_next    = rr;
        M_GNT      = 2'b00;
        case (state)
            S_IDLE: begin
                if (grant_any) begin
                    M_GNT[winner] = !RST;
                    rr_next       = ~winner;
                    state_next    = S_ACCESS;
                end
            end
            S_ACCESS: state_next = S_RESP;
            S_RESP:   state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    // Load path: bring the addressed lane down to bit 0, then extend.
    always_comb begin
        shifted   = RDATA >> {addr_q[1:0], 3'b000};
        load_data = RDATA;
        case (size_q)
            2'b00:   load_data = signed_q ? {{24{shifted[7]}}, shifted[7:0]}
                                          : {24'd0, shifted[7:0]};
            2'b01:   load_data = signed_q ? {{16{shifted[15]}}, shifted[15:0]}
                                          : {16'd0, shifted[15:0]};
            default: load_data = RDATA;
        endcase
    end

    // Store path: read-modify-write merge of the addressed lane(s).
    always_comb begin
        store_data = RDATA;
        case (size_q)
            2'b00: begin
                case (addr_q[1:0])
                    2'd0:    store_data[7:0]   = wdata_q[7:0];
                    2'd1:    store_data[15:8]  = wdata_q[7:0];
                    2'd2:    store_data[23:16] = wdata_q[7:0];
                    default: store_data[31:24] = wdata_q[7:0];
                endcase
            end
            2'b01: begin
                if (addr_q[1]) begin
                    store_data[31:16] = wdata_q[15:0];
                end else begin
                    store_data[15:0] = wdata_q[15:0];
                end
            end
            default: store_data = wdata_q;
        endcase
    end

    always_comb begin
        word_idx = {2'b00, addr_q[31:2]};
        ARADDR   = (state == S_ACCESS) ? word_idx : 32'd0;
        AWADDR   = (state == S_ACCESS) ? word_idx : 32'd0;
        WDATA    = (state == S_ACCESS) ? store_data : 32'd0;
        AWVALID  = (state == S_ACCESS) && we_q && !err_q && !RST;
        M_RVALID = 2'b00;
        M_RDATA  = 32'd0;
        M_ERR    = 1'b0;
        if (state == S_RESP && !RST) begin
            M_RVALID[port_q] = 1'b1;
            M_RDATA          = result_q;
            M_ERR            = err_q;
        end
    end

endmodule
